// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RISC-V controller: FSM states, opcodes,
// ALU operation selects and immediate formats.
package riscv_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } aluctrl_t;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } immsrc_t;

  // Immediate format is a pure function of the opcode; unknown opcodes use I-type
  function automatic logic [1:0] immSrcOf(input logic [6:0] op);
    logic [1:0] imm;
    imm = IMM_I;
    case (op)
      OP_STORE:  imm = IMM_S;
      OP_BRANCH: imm = IMM_B;
      OP_JAL:    imm = IMM_J;
      default:   imm = IMM_I;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU operation select from the FSM's ALUOp class and the instruction funct fields.
module alu_decoder
  import riscv_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       op5_i,
  input  logic       funct7_5_i,
  output logic [2:0] alu_ctrl_o
);

  // Subtract is only an R-type encoding; addi with Instr[30] set still adds
  always_comb begin
    alu_ctrl_o = ALU_ADD;
    case (alu_op_i)
      ALUOP_ADD: alu_ctrl_o = ALU_ADD;
      ALUOP_SUB: alu_ctrl_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          3'b000: begin
            if (op5_i && funct7_5_i) alu_ctrl_o = ALU_SUB;
            else                     alu_ctrl_o = ALU_ADD;
          end
          3'b010:  alu_ctrl_o = ALU_SLT;
          3'b110:  alu_ctrl_o = ALU_OR;
          3'b111:  alu_ctrl_o = ALU_AND;
          default: alu_ctrl_o = ALU_ADD;
        endcase
      end
      default: alu_ctrl_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/riscv_multi_ctrl.sv
// Multicycle RISC-V control unit: Moore FSM sequencing a shared-memory datapath,
// with outputs decoded from the current state, funct fields and Zero.
module riscv_multi_ctrl
  import riscv_pkg::*;
#(
  parameter int MEM_WAIT_EN = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       Mem_Write,
  output logic       Reg_Write,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUCtrl,
  output logic       illegal,
  output logic [3:0] state
);

  state_t state_q, state_d;
  aluop_t aluOp;
  logic   memReady;
  logic   pcUpdate;
  logic   branch;

  assign memReady = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: if (memReady) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECUTER;
          OP_ITYPE:          state_d = S_EXECUTEI;
          OP_BRANCH:         state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        if (opcode[5]) state_d = S_MEMWRITE;
        else           state_d = S_MEMREAD;
      end
      S_MEMREAD:  if (memReady) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (memReady) state_d = S_FETCH;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_JAL:      state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_ILLEGAL:  state_d = S_ILLEGAL;
      default:    state_d = S_FETCH;
    endcase
  end

  // Async reset lands in FETCH so write enables drop without waiting for a clock
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    pcUpdate  = 1'b0;
    branch    = 1'b0;
    aluOp     = ALUOP_ADD;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    Mem_Write = 1'b0;
    Reg_Write = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    illegal   = 1'b0;
    case (state_q)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = memReady;
        pcUpdate  = memReady;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        Reg_Write = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc    = 1'b1;
        Mem_Write = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA = 2'b10;
        aluOp   = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        aluOp   = ALUOP_FUNCT;
      end
      S_JAL: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        pcUpdate = 1'b1;
      end
      S_ALUWB: Reg_Write = 1'b1;
      S_BEQ: begin
        ALUSrcA = 2'b10;
        aluOp   = ALUOP_SUB;
        branch  = 1'b1;
      end
      S_ILLEGAL: illegal = 1'b1;
      default: ;
    endcase
  end

  assign PCWrite = pcUpdate | (branch & Zero);
  assign ImmSrc  = immSrcOf(opcode);
  assign state   = state_q;

  alu_decoder u_alu_decoder (
    .alu_op_i   (aluOp),
    .funct3_i   (funct3),
    .op5_i      (opcode[5]),
    .funct7_5_i (funct7_5),
    .alu_ctrl_o (ALUCtrl)
  );

endmodule

// File: tb/tb_riscv_multi_ctrl.sv
// Bench for riscv_multi_ctrl: an instruction-level reference model checked every
// cycle, plus directed instruction traces with hand-worked expectations.
module tb_riscv_multi_ctrl;

  localparam logic [3:0] ST_FETCH    = 4'd0;
  localparam logic [3:0] ST_DECODE   = 4'd1;
  localparam logic [3:0] ST_MEMADR   = 4'd2;
  localparam logic [3:0] ST_MEMREAD  = 4'd3;
  localparam logic [3:0] ST_MEMWB    = 4'd4;
  localparam logic [3:0] ST_MEMWRITE = 4'd5;
  localparam logic [3:0] ST_EXECR    = 4'd6;
  localparam logic [3:0] ST_EXECI    = 4'd7;
  localparam logic [3:0] ST_ALUWB    = 4'd8;
  localparam logic [3:0] ST_BEQ      = 4'd9;
  localparam logic [3:0] ST_JAL      = 4'd10;
  localparam logic [3:0] ST_ILLEGAL  = 4'd11;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5, Zero, mem_ready;
  logic       PCWrite, AdrSrc, IRWrite, Mem_Write, Reg_Write, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUCtrl;
  logic [3:0] state;

  int vectors = 0;
  int miscompares = 0;
  logic checkOn = 1'b0;

  typedef struct packed {
    logic       pcw, adr, irw, mw, rw;
    logic [1:0] rs, sa, sb, imm;
    logic [2:0] alu;
    logic       ill;
    logic [3:0] st;
  } outs_t;

  logic [3:0] mState;
  logic [3:0] plan[$];

  logic [3:0] trState [1:16];
  logic       trRw [1:16], trPcw [1:16], trIrw [1:16], trMw [1:16], trIll [1:16];
  logic [2:0] trAlu [1:16];
  logic [1:0] trRs [1:16];
  logic [3:0] lwSeq [0:4];

  riscv_multi_ctrl #(.MEM_WAIT_EN(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7_5  (funct7_5),
    .Zero      (Zero),
    .mem_ready (mem_ready),
    .PCWrite   (PCWrite),
    .AdrSrc    (AdrSrc),
    .IRWrite   (IRWrite),
    .Mem_Write (Mem_Write),
    .Reg_Write (Reg_Write),
    .ResultSrc (ResultSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ImmSrc    (ImmSrc),
    .ALUCtrl   (ALUCtrl),
    .illegal   (illegal),
    .state     (state)
  );

  always #5 clk = ~clk;

  // Each instruction is a fixed list of phases chosen when FETCH completes;
  // only FETCH, MEMREAD and MEMWRITE wait on memory, and ILLEGAL never leaves
  function automatic logic [3:0] stepModel(input logic [3:0] cur, input logic [6:0] op, input logic mr);
    if (cur == ST_FETCH) begin
      if (!mr) return cur;
      plan.delete();
      case (op)
        7'b0000011: plan = {ST_DECODE, ST_MEMADR, ST_MEMREAD, ST_MEMWB};
        7'b0100011: plan = {ST_DECODE, ST_MEMADR, ST_MEMWRITE};
        7'b0110011: plan = {ST_DECODE, ST_EXECR, ST_ALUWB};
        7'b0010011: plan = {ST_DECODE, ST_EXECI, ST_ALUWB};
        7'b1100011: plan = {ST_DECODE, ST_BEQ};
        7'b1101111: plan = {ST_DECODE, ST_JAL, ST_ALUWB};
        default:    plan = {ST_DECODE, ST_ILLEGAL};
      endcase
      return plan.pop_front();
    end
    if (cur == ST_ILLEGAL) return cur;
    if ((cur == ST_MEMREAD || cur == ST_MEMWRITE) && !mr) return cur;
    if (plan.size() == 0) return ST_FETCH;
    return plan.pop_front();
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      plan.delete();
      mState <= ST_FETCH;
    end else begin
      mState <= stepModel(mState, opcode, mem_ready);
    end
  end

  // Expected datapath controls for a phase, straight from the phase tables
  function automatic outs_t expOf(input logic [3:0] st, input logic [6:0] op, input logic [2:0] f3,
                                  input logic f75, input logic z, input logic mr);
    outs_t e;
    logic [2:0] arith;
    e = '0;
    e.st = st;
    case (f3)
      3'b000:  arith = (op[5] && f75) ? 3'b001 : 3'b000;
      3'b010:  arith = 3'b101;
      3'b110:  arith = 3'b011;
      3'b111:  arith = 3'b010;
      default: arith = 3'b000;
    endcase
    case (op)
      7'b0100011: e.imm = 2'b01;
      7'b1100011: e.imm = 2'b10;
      7'b1101111: e.imm = 2'b11;
      default:    e.imm = 2'b00;
    endcase
    case (st)
      ST_FETCH:    begin e.sb = 2'b10; e.rs = 2'b10; e.irw = mr; e.pcw = mr; end
      ST_DECODE:   begin e.sa = 2'b01; e.sb = 2'b01; end
      ST_MEMADR:   begin e.sa = 2'b10; e.sb = 2'b01; end
      ST_MEMREAD:  e.adr = 1'b1;
      ST_MEMWB:    begin e.rs = 2'b01; e.rw = 1'b1; end
      ST_MEMWRITE: begin e.adr = 1'b1; e.mw = 1'b1; end
      ST_EXECR:    begin e.sa = 2'b10; e.alu = arith; end
      ST_EXECI:    begin e.sa = 2'b10; e.sb = 2'b01; e.alu = arith; end
      ST_JAL:      begin e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1'b1; end
      ST_ALUWB:    e.rw = 1'b1;
      ST_BEQ:      begin e.sa = 2'b10; e.alu = 3'b001; e.pcw = z; end
      ST_ILLEGAL:  e.ill = 1'b1;
      default:     ;
    endcase
    return e;
  endfunction

  // Whole-output comparison against the model on every falling edge
  always @(negedge clk) begin
    outs_t e, a;
    if (checkOn) begin
      e = expOf(mState, opcode, funct3, funct7_5, Zero, mem_ready);
      a = {PCWrite, AdrSrc, IRWrite, Mem_Write, Reg_Write, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, ALUCtrl, illegal, state};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("[TB] FAIL model_cycle t=%0t: actual %b required %b (model phase %0d)",
                 $time, a, e, mState);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    vectors++;
    if (actual !== required) begin
      miscompares++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, actual, required);
    end
  endtask

  // Runs one instruction from its FETCH cycle; readyMask bit c-1 is mem_ready in cycle c
  task automatic applyStimulus(input logic [6:0] opc, input logic [2:0] f3, input logic f75,
                               input logic z, input logic [15:0] readyMask, input int cycles);
    opcode   = opc;
    funct3   = f3;
    funct7_5 = f75;
    Zero     = z;
    for (int c = 1; c <= cycles; c++) begin
      mem_ready = readyMask[c-1];
      @(negedge clk);
      #2;
      trState[c] = state;
      trRw[c]    = Reg_Write;
      trPcw[c]   = PCWrite;
      trIrw[c]   = IRWrite;
      trMw[c]    = Mem_Write;
      trIll[c]   = illegal;
      trAlu[c]   = ALUCtrl;
      trRs[c]    = ResultSrc;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    lwSeq     = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    reset     = 1'b0;
    opcode    = 7'b0000011;
    funct3    = 3'b010;
    funct7_5  = 1'b0;
    Zero      = 1'b0;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOn = 1'b1;

    @(negedge clk);
    #2;
    checkOutput("rst_state", state, ST_FETCH);
    checkOutput("rst_irwrite", IRWrite, 1);
    checkOutput("rst_pcwrite", PCWrite, 1);
    checkOutput("rst_resultsrc", ResultSrc, 2'b10);
    mem_ready = 1'b0;
    #1;
    checkOutput("rst_irwrite_gated", IRWrite, 0);
    checkOutput("rst_pcwrite_gated", PCWrite, 0);
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b1;

    applyStimulus(7'b0000011, 3'b010, 1'b0, 1'b0, 16'hFFFF, 5);
    for (int c = 1; c <= 5; c++) begin
      checkOutput($sformatf("lw_state_c%0d", c), trState[c], lwSeq[c-1]);
      checkOutput($sformatf("lw_regwrite_c%0d", c), trRw[c], (c == 5) ? 1 : 0);
    end
    checkOutput("lw_resultsrc_c5", trRs[5], 2'b01);

    applyStimulus(7'b0100011, 3'b010, 1'b0, 1'b0, 16'hFFFF, 4);
    checkOutput("sw_state_c4", trState[4], ST_MEMWRITE);
    checkOutput("sw_memwrite_c4", trMw[4], 1);
    checkOutput("sw_memwrite_c3", trMw[3], 0);

    applyStimulus(7'b1100011, 3'b000, 1'b0, 1'b1, 16'hFFFF, 3);
    checkOutput("beq_taken_state", trState[3], ST_BEQ);
    checkOutput("beq_taken_pcwrite", trPcw[3], 1);
    checkOutput("beq_taken_aluctrl", trAlu[3], 3'b001);
    applyStimulus(7'b1100011, 3'b000, 1'b0, 1'b0, 16'hFFFF, 3);
    checkOutput("beq_nottaken_pcwrite", trPcw[3], 0);

    applyStimulus(7'b0110011, 3'b000, 1'b1, 1'b0, 16'hFFFF, 4);
    checkOutput("rsub_state", trState[3], ST_EXECR);
    checkOutput("rsub_aluctrl", trAlu[3], 3'b001);
    checkOutput("rsub_regwrite_c4", trRw[4], 1);
    applyStimulus(7'b0110011, 3'b110, 1'b0, 1'b0, 16'hFFFF, 4);
    checkOutput("ror_aluctrl", trAlu[3], 3'b011);
    applyStimulus(7'b0110011, 3'b010, 1'b0, 1'b0, 16'hFFFF, 4);
    checkOutput("rslt_aluctrl", trAlu[3], 3'b101);
    applyStimulus(7'b0110011, 3'b111, 1'b0, 1'b0, 16'hFFFF, 4);
    checkOutput("rand_aluctrl", trAlu[3], 3'b010);

    applyStimulus(7'b0010011, 3'b000, 1'b1, 1'b0, 16'hFFFF, 4);
    checkOutput("addi_state", trState[3], ST_EXECI);
    checkOutput("addi_f75_still_add", trAlu[3], 3'b000);

    applyStimulus(7'b1101111, 3'b000, 1'b0, 1'b0, 16'hFFFF, 4);
    checkOutput("jal_state", trState[3], ST_JAL);
    checkOutput("jal_pcwrite", trPcw[3], 1);
    checkOutput("jal_wb_state", trState[4], ST_ALUWB);

    applyStimulus(7'b0110011, 3'b000, 1'b0, 1'b0, 16'hFFF8, 7);
    for (int c = 1; c <= 3; c++) begin
      checkOutput($sformatf("stall_irwrite_c%0d", c), trIrw[c], 0);
      checkOutput($sformatf("stall_pcwrite_c%0d", c), trPcw[c], 0);
    end
    checkOutput("stall_irwrite_c4", trIrw[4], 1);
    checkOutput("stall_decode_c5", trState[5], ST_DECODE);

    applyStimulus(7'b0000011, 3'b010, 1'b0, 1'b0, 16'hFFF7, 6);
    checkOutput("lwwait_c4", trState[4], ST_MEMREAD);
    checkOutput("lwwait_c5", trState[5], ST_MEMREAD);
    checkOutput("lwwait_c6", trState[6], ST_MEMWB);

    applyStimulus(7'b0000000, 3'b000, 1'b0, 1'b1, 16'hFFFF, 12);
    for (int c = 3; c <= 12; c++) begin
      checkOutput($sformatf("ill_state_c%0d", c), trState[c], ST_ILLEGAL);
      checkOutput($sformatf("ill_flag_c%0d", c), trIll[c], 1);
      checkOutput($sformatf("ill_enables_c%0d", c),
                  {trPcw[c], trIrw[c], trMw[c], trRw[c]}, 4'b0000);
    end
    reset = 1'b0;
    #1;
    checkOutput("ill_reset_state", state, ST_FETCH);
    checkOutput("ill_reset_flag", illegal, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    applyStimulus(7'b0100011, 3'b010, 1'b0, 1'b0, 16'h0007, 5);
    checkOutput("swwait_c5_state", trState[5], ST_MEMWRITE);
    checkOutput("swwait_c5_memwrite", trMw[5], 1);
    #2;
    checkOutput("swwait_pre_reset", Mem_Write, 1);
    reset = 1'b0;
    #1;
    checkOutput("swrst_memwrite", Mem_Write, 0);
    checkOutput("swrst_state", state, ST_FETCH);
    @(posedge clk);
    #1;
    reset = 1'b1;
    mem_ready = 1'b1;

    applyStimulus(7'b0110011, 3'b000, 1'b0, 1'b0, 16'hFFFF, 4);
    checkOutput("post_reset_radd", trAlu[3], 3'b000);

    @(negedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/riscv_multi_ctrl.md
RISCV_MULTI_CTRL -- requirements
Module: riscv_multi_ctrl

Interface
REQ-001 Parameter: MEM_WAIT_EN, default 1, meaning 1 = honour mem_ready and 0 = treat mem_ready as constantly 1.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 opcode  input  7  Instr[6:0] from the datapath instruction register.
REQ-005 funct3  input  3  Instr[14:12].
REQ-006 funct7_5  input  1  Instr[30].
REQ-007 Zero  input  1  ALU zero flag.
REQ-008 mem_ready  input  1  shared instruction/data memory completes the current access this cycle.
REQ-009 PCWrite, AdrSrc, IRWrite, Mem_Write, Reg_Write  output  1 each  datapath enables and selects.
REQ-010 ResultSrc, ALUSrcA, ALUSrcB, ImmSrc  output  2 each  datapath mux selects.
REQ-011 ALUCtrl  output  3  ALU operation select.
REQ-012 illegal  output  1  unsupported opcode trapped.
REQ-013 state  output  4  current FSM state, for debug.

Function
REQ-014 Moore FSM: all outputs decode from state, funct fields and Zero only; PCWrite = PCUpdate | (Branch & Zero).
REQ-015 FETCH: AdrSrc=0, ALUSrcA=00 (PC), ALUSrcB=10 (const 4), ALUOp=00, ResultSrc=10; IRWrite=PCUpdate=mem_ready; go to DECODE on mem_ready, else stay.
REQ-016 DECODE: ALUSrcA=01 (OldPC), ALUSrcB=01 (Imm), ALUOp=00.
REQ-016a DECODE next state by opcode: 0000011/0100011 -> MEMADR, 0110011 -> EXECUTER, 0010011 -> EXECUTEI, 1100011 -> BEQ, 1101111 -> JAL, any other -> ILLEGAL.
REQ-017 MEMADR: ALUSrcA=10 (rs1), ALUSrcB=01, ALUOp=00; go to MEMREAD if opcode[5]=0, else MEMWRITE.
REQ-018 MEMREAD: AdrSrc=1, ResultSrc=00; go to MEMWB on mem_ready, else stay.
REQ-018a MEMWB: ResultSrc=01, Reg_Write=1; go to FETCH.
REQ-019 MEMWRITE: AdrSrc=1, ResultSrc=00, Mem_Write=1 held until mem_ready; go to FETCH on mem_ready.
REQ-020 EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Both go to ALUWB.
REQ-021 JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1; go to ALUWB.
REQ-021a ALUWB: ResultSrc=00, Reg_Write=1; go to FETCH.
REQ-022 BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1; go to FETCH.
REQ-023 ILLEGAL: illegal=1; all write enables are 0; the state is held until reset.
REQ-024 Unlisted outputs are 0 in every state.
REQ-025 ImmSrc decodes from opcode in all states: I-type=00, S=01, B=10, J=11, other=00.
REQ-026 ALU decode: ALUOp 00 -> add 000; ALUOp 01 -> sub 001.
REQ-026a ALU decode, ALUOp 10, by funct3: 000 -> sub 001 if opcode[5] & funct7_5, else add 000; 010 -> slt 101; 110 -> or 011; 111 -> and 010; other -> 000.
REQ-027 Latency with mem_ready=1: lw 5 cycles; sw, R, I and jal 4 cycles; beq 3 cycles. Each mem_ready=0 cycle in a wait state adds 1.

Reset
REQ-028 reset=0 forces state=FETCH and illegal=0 asynchronously, from any state including MEMWRITE mid-access; Mem_Write and Reg_Write drop without waiting for a clock.
REQ-029 Outputs during reset equal the FETCH decode; IRWrite and PCWrite are gated by mem_ready.

Structure
REQ-030 Shared package riscv_pkg holds the state encoding, the opcode constants, and the ALUCtrl, ALUOp and ImmSrc encodings.
REQ-031 ALU decode lives in one sub-module, alu_decoder; the FSM and output decode live in riscv_multi_ctrl.

Verification
REQ-032 lw (opcode 0000011), mem_ready=1 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH; Reg_Write=1 only in cycle 5, with ResultSrc=01.
REQ-033 beq, Zero=1 -> PCWrite=1 in the BEQ cycle, ALUCtrl=001. Zero=0 -> PCWrite=0 in the BEQ cycle.
REQ-034 FETCH with mem_ready low for 3 cycles -> IRWrite=0 and PCWrite=0 for those 3 cycles; IRWrite=1 on cycle 4; DECODE on cycle 5.
REQ-035 R-type, funct3=000, funct7_5=1 -> ALUCtrl=001 in EXECUTER. funct3=110 -> 011.
REQ-036 opcode 0000000 -> ILLEGAL after DECODE; illegal=1 and all enables 0 for 10+ cycles; reset then returns the FSM to FETCH.
REQ-037 sw with mem_ready=0, reset asserted mid-MEMWRITE -> Mem_Write=0 and state=FETCH before the next clk edge.
